// File: rtl/io_ctrl.sv
// Memory-mapped I/O and RAM bridge behind the CPU byte bus: address steering,
// UART TX FIFO, RX byte path, cycle counter with snapshot and program-stop flag.
module io_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_finish,
    output logic        overflow_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH - FULL_MARGIN);

    localparam logic [15:0] OFF_UART = 16'h0000;
    localparam logic [15:0] OFF_CNT0 = 16'h0004;
    localparam logic [15:0] OFF_CNT1 = 16'h0005;
    localparam logic [15:0] OFF_CNT2 = 16'h0006;
    localparam logic [15:0] OFF_CNT3 = 16'h0007;

    logic          is_io;
    logic [15:0]   io_off;
    logic          cpu_req;
    logic          io_rd;
    logic          io_wr;
    logic          push;
    logic [7:0]    push_data;
    logic          pop;
    logic          fifo_full;
    logic          push_ok;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [31:0]   cycle_cnt;
    logic [31:0]   snap;
    logic [7:0]    io_rdata;
    logic [7:0]    io_rdata_next;
    logic          sel_ram;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^cpu_a[31:18];

    assign is_io   = cpu_a[17:16] == 2'b11;
    assign io_off  = cpu_a[15:0];
    // Reset gates every CPU-side strobe so nothing leaks out while rst_in is low.
    assign cpu_req = rst_in & rdy_in;
    assign io_rd   = cpu_req & is_io & ~cpu_wr;
    assign io_wr   = cpu_req & is_io & cpu_wr;

    assign ram_en   = cpu_req & ~is_io;
    assign ram_wr   = ram_en & cpu_wr;
    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;

    assign rx_pop = io_rd & (io_off == OFF_UART) & rx_valid;

    assign push      = io_wr & (((io_off == OFF_UART) & (cpu_dout != 8'h00)) |
                                (io_off == OFF_CNT0));
    assign push_data = (io_off == OFF_CNT0) ? 8'h00 : cpu_dout;

    assign tx_valid  = count != '0;
    assign tx_data   = fifo_mem[rd_ptr];
    assign pop       = tx_valid & tx_ready;
    assign fifo_full = count == DEPTH_CNT;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still safe.
    assign push_ok   = push & (~fifo_full | pop);

    assign cpu_din = sel_ram ? ram_din : io_rdata;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        io_rdata_next = 8'h00;
        case (io_off)
            OFF_UART: io_rdata_next = rx_valid ? rx_data : 8'h00;
            OFF_CNT0: io_rdata_next = cycle_cnt[7:0];
            OFF_CNT1: io_rdata_next = snap[15:8];
            OFF_CNT2: io_rdata_next = snap[23:16];
            OFF_CNT3: io_rdata_next = snap[31:24];
            default:  io_rdata_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            overflow_err   <= 1'b0;
            program_finish <= 1'b0;
            cycle_cnt      <= '0;
            snap           <= '0;
            io_rdata       <= 8'h00;
            sel_ram        <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count          <= count_next;
            io_buffer_full <= count_next >= FULL_LEVEL;
            if (push & fifo_full & ~pop) begin
                overflow_err <= 1'b1;
            end
            if (io_wr & (io_off == OFF_CNT0)) begin
                program_finish <= 1'b1;
            end
            if (rdy_in) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (!cpu_wr) begin
                    sel_ram <= ~is_io;
                    if (is_io) begin
                        io_rdata <= io_rdata_next;
                    end
                    // Byte 0 comes from the live counter; bytes 1..3 from this snapshot.
                    if (is_io & (io_off == OFF_CNT0)) begin
                        snap <= cycle_cnt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// Scoreboard bench for io_ctrl: stimulus queues expected read and TX bytes,
// monitors pop and compare when the DUT presents them.
module tb_io_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic        ram_en;
    logic        ram_wr;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_finish;
    logic        overflow_err;

    localparam logic [31:0] IDLE_A = 32'h0003_FFF0;

    int n_vec = 0;
    int n_err = 0;
    int pop_cnt = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    logic rd_chk = 1'b0;
    logic rd_pend = 1'b0;
    logic [7:0] ram_mem [0:131071];

    io_ctrl #(.FIFO_DEPTH(8), .FULL_MARGIN(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .program_finish(program_finish), .overflow_err(overflow_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_wr) ram_mem[ram_a] <= ram_dout;
            else        ram_din <= ram_mem[ram_a];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read-return monitor: a checked read issued this cycle is compared one cycle later.
    always @(negedge clk_in) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_unexpected: got 0x%0h with no read expected", cpu_din);
            end else begin
                chk("cpu_din", {24'h0, cpu_din}, {24'h0, rd_q.pop_front()});
            end
        end
        rd_pend = rst_in & rdy_in & ~cpu_wr & rd_chk;
    end

    always @(negedge clk_in) begin
        if (rst_in && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL tx_unexpected: got 0x%0h with nothing expected", tx_data);
            end else begin
                chk("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
        end
        if (rx_pop) pop_cnt++;
    end

    task automatic set_idle();
        cpu_a = IDLE_A; cpu_wr = 1'b0; cpu_dout = 8'h00; rdy_in = 1'b1; rd_chk = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a; cpu_wr = 1'b1; cpu_dout = d; rdy_in = 1'b1; rd_chk = 1'b0;
        step(1);
        set_idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        cpu_a = a; cpu_wr = 1'b0; rdy_in = 1'b1; rd_chk = 1'b1;
        rd_q.push_back(exp);
        step(1);
        set_idle();
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        step(1);
        rst_in = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && tx_q.size() != 0; i++) step(1);
        chk(name, tx_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        ram_mem[17'h00100] = 8'h5A;
        ram_din = 8'h00; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        set_idle();
        rst_in = 1'b0;
        step(2);
        rst_in = 1'b1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_buf_full", io_buffer_full, 0);
        chk("rst_finish", program_finish, 0);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_cpu_din", cpu_din, 0);

        // TX: zero data to 0x30000 is dropped
        tx_ready = 1'b1;
        tx_q.push_back(8'h41); wr(32'h30000, 8'h41);
        tx_q.push_back(8'h42); wr(32'h30000, 8'h42);
        wr(32'h30000, 8'h00);
        step(3);
        chk("t1_tx_idle", tx_valid, 0);
        chk("t1_q_empty", tx_q.size(), 0);

        // Fill with no drain, overflow, then drain across pointer wrap
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tx_q.push_back(8'h11 + 8'(i));
            wr(32'h30000, 8'h11 + 8'(i));
            if (i == 4) chk("full_at5", io_buffer_full, 0);
        end
        chk("full_at6", io_buffer_full, 1);
        tx_q.push_back(8'h17); wr(32'h30000, 8'h17);
        tx_q.push_back(8'h18); wr(32'h30000, 8'h18);
        chk("ovf_at8", overflow_err, 0);
        wr(32'h30000, 8'h19);
        chk("ovf_at9", overflow_err, 1);
        chk("full_tx_valid", tx_valid, 1);
        tx_ready = 1'b1;
        drain("t2_drain");
        step(2);
        chk("t2_tx_idle", tx_valid, 0);
        chk("t2_full_clear", io_buffer_full, 0);
        chk("t2_ovf_sticky", overflow_err, 1);

        // RAM read and write
        cpu_a = 32'h00100; cpu_wr = 1'b0; rd_chk = 1'b1; rd_q.push_back(8'h5A);
        #1;
        chk("ram_rd_en", ram_en, 1);
        chk("ram_rd_wr", ram_wr, 0);
        chk("ram_rd_a", ram_a, 32'h00100);
        step(1);
        set_idle();
        cpu_a = 32'h1FFFF; cpu_wr = 1'b1; cpu_dout = 8'hC3;
        #1;
        chk("ram_wr_en", ram_en, 1);
        chk("ram_wr_wr", ram_wr, 1);
        chk("ram_wr_a", ram_a, 32'h1FFFF);
        chk("ram_wr_dout", ram_dout, 32'hC3);
        step(1);
        set_idle();
        #1;
        chk("io_no_ram_en", ram_en, 0);
        step(1);
        rd(32'h1FFFF, 8'hC3);

        // RX path
        p0 = pop_cnt;
        rx_valid = 1'b1; rx_data = 8'h37;
        rd(32'h30000, 8'h37);
        rx_valid = 1'b0;
        chk("rx_pop_once", pop_cnt, p0 + 1);
        rd(32'h30000, 8'h00);
        chk("rx_no_pop", pop_cnt, p0 + 1);
        step(1);

        // Counter snapshot; counter reads 0xFE in the cycle after 254 counting edges
        do_reset();
        step(254);
        rd(32'h30004, 8'hFE);
        rd(32'h30005, 8'h00);
        rd(32'h30006, 8'h00);
        rd(32'h30007, 8'h00);
        p0 = pop_cnt;
        rdy_in = 1'b0; rx_valid = 1'b1; rx_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            cpu_a = (i % 2 == 0) ? 32'h00100 : 32'h30000;
            cpu_wr = 1'b0;
            #1;
            if (i == 0) chk("rdy0_ram_en", ram_en, 0);
            step(1);
        end
        rx_valid = 1'b0;
        chk("rdy0_no_pop", pop_cnt, p0);
        set_idle();
        rd(32'h30004, 8'h02);
        rd(32'h30005, 8'h01);

        // Program finish, then reset with bytes still queued
        tx_ready = 1'b1;
        tx_q.push_back(8'h00); wr(32'h30004, 8'hAA);
        chk("finish_set", program_finish, 1);
        tx_q.push_back(8'h55); wr(32'h30000, 8'h55);
        step(3);
        chk("finish_sticky", program_finish, 1);
        chk("t6_q_empty", tx_q.size(), 0);
        tx_ready = 1'b0;
        wr(32'h30000, 8'h61);
        wr(32'h30000, 8'h62);
        wr(32'h30000, 8'h63);
        chk("queued_valid", tx_valid, 1);
        rst_in = 1'b0;
        cpu_a = 32'h00100;
        #1;
        chk("rst_ram_en", ram_en, 0);
        step(1);
        rst_in = 1'b1;
        set_idle();
        chk("rst2_tx_valid", tx_valid, 0);
        chk("rst2_finish", program_finish, 0);
        chk("rst2_overflow", overflow_err, 0);
        chk("rst2_buf_full", io_buffer_full, 0);
        chk("rst2_cpu_din", cpu_din, 0);
        rd(32'h30004, 8'h00);
        tx_ready = 1'b1;
        step(3);
        chk("end_rd_q", rd_q.size(), 0);
        chk("end_tx_q", tx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_ctrl.md
Name: io_ctrl

Overview:
- Memory-mapped I/O and RAM bridge directly downstream of the CPU top's byte-wide memory bus (mem_a / mem_dout / mem_wr / mem_din / io_buffer_full).
- Steers accesses to the 128KB RAM or to the I/O space (mem_a[17:16]==2'b11).
- Owns the UART TX FIFO, the RX byte path, the 32-bit cycle counter and the program-stop flag.
- Produces the io_buffer_full back-pressure signal the CPU consumes.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 4.
- FULL_MARGIN, 2, free slots reserved for in-flight CPU writes when io_buffer_full asserts.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  synchronous, active-low reset.
- rdy_in  input  1  CPU-side enable; when low, CPU accesses and the counter are frozen.
- cpu_a  input  32  CPU address (mem_a); only bits 17:0 are decoded.
- cpu_dout  input  8  CPU write data (mem_dout).
- cpu_wr  input  1  1 = write, 0 = read (mem_wr).
- cpu_din  output  8  read data to CPU (mem_din), valid the cycle after the request.
- io_buffer_full  output  1  TX FIFO back-pressure to the CPU.
- ram_en  output  1  RAM access strobe.
- ram_wr  output  1  RAM write enable.
- ram_a  output  17  RAM byte address.
- ram_dout  output  8  RAM write data.
- ram_din  input  8  RAM read data, one cycle after ram_en.
- rx_data  input  8  UART RX head byte.
- rx_valid  input  1  RX byte available.
- rx_pop  output  1  consume the RX head byte.
- tx_data  output  8  UART TX byte.
- tx_valid  output  1  TX byte available.
- tx_ready  input  1  UART accepts tx_data this cycle.
- program_finish  output  1  sticky stop flag.
- overflow_err  output  1  sticky: a write arrived while the FIFO was truly full.

Behaviour:
- Decode is combinational: is_io = cpu_a[17:16]==2'b11.
  - RAM path: ram_en = rdy_in & ~is_io; ram_wr = ram_en & cpu_wr; ram_a = cpu_a[16:0]; ram_dout = cpu_dout.
- Read mux:
  - A registered select latches {ram, io} on each read with rdy_in high.
  - cpu_din next cycle = ram_din when the select is ram, otherwise the registered io_rdata.
  - Read latency is exactly 1 cycle for both RAM and I/O.
- IO read 0x30000:
  - rx_valid=1: io_rdata <= rx_data and rx_pop pulses for 1 cycle in the request cycle.
  - rx_valid=0: io_rdata <= 0x00 and rx_pop stays 0.
- IO read 0x30004..0x30007:
  - A read of 0x30004 loads a snapshot of the counter and returns byte 0.
  - Reads of 0x30005..0x30007 return snapshot bytes 1..3 (little-endian), so a 4-byte read is self-consistent.
  - A read of 0x30004 returns the live counter byte 0 in the same cycle the snapshot loads.
- All other IO reads return 0x00. All other IO writes are ignored.
- Cycle counter: 32-bit, +1 every cycle rdy_in=1, wraps 0xFFFFFFFF to 0.
- IO write 0x30000:
  - Nonzero cpu_dout is pushed to the TX FIFO.
  - 0x00 is ignored.
- IO write 0x30004:
  - Pushes 0x00 terminator into the TX FIFO and sets program_finish (sticky until reset).
  - Further writes to 0x30000 are still accepted.
- TX FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers and a count register.
  - tx_valid = count!=0; tx_data = head entry.
  - Pop occurs when tx_valid & tx_ready, independent of rdy_in.
  - Simultaneous push and pop leaves count unchanged; allowed even when full, since the pop frees the slot in the same cycle.
  - Push when count==FIFO_DEPTH with no pop: byte dropped, overflow_err set (sticky).
  - Pointers wrap modulo FIFO_DEPTH.
- io_buffer_full is registered: 1 when next count >= FIFO_DEPTH-FULL_MARGIN.
- rdy_in=0:
  - ram_en=0, no push, rx_pop=0, counter holds, read select and io_rdata hold.
  - TX drain continues.
- Reset (rst_in=0 at clk edge), applies mid-transfer and discards FIFO contents:
  - FIFO empty, counter 0, snapshot 0.
  - cpu_din, io_rdata, tx_valid, rx_pop, io_buffer_full, program_finish, overflow_err all 0.
  - ram_en=0 (gated on reset).

Test Plan:
- Reset, then write 0x41,0x42,0x00 to 0x30000 with tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive cycles; 0x00 never appears; tx_valid returns to 0.
- tx_ready=0, DEPTH=8: write 6 bytes -> io_buffer_full=1 after the 6th. Write 3 more -> 8 stored, 9th dropped, overflow_err=1. Raise tx_ready -> exactly 8 bytes drain in order, wrapping the pointers.
- Read RAM 0x00100 after the RAM model has 0x5A there -> ram_en=1, ram_wr=0 and ram_a=0x00100 in cycle N; cpu_din=0x5A in cycle N+1. Same for write 0x1FFFF data 0xC3 -> ram_wr=1 with ram_dout=0xC3.
- rx_valid=1, rx_data=0x37, read 0x30000 -> rx_pop pulses once, cpu_din=0x37 next cycle. Repeat with rx_valid=0 -> cpu_din=0x00, no pop.
- Counter preset near wrap (run to 0x000000FE). Read 0x30004..0x30007 on consecutive cycles -> bytes FE,00,00,00 from the snapshot despite live increments. Hold rdy_in=0 for 5 cycles -> counter unchanged.
- Write 0x30004 -> program_finish=1 sticky and tx_data=0x00 emitted. Assert rst_in=0 with 3 bytes queued -> next cycle tx_valid=0, program_finish=0, counter=0.
